// File: rtl/ptw_arbiter.sv
// Shares one page-table-walk memory read port between the I-side and D-side
// Sv32 MMUs, holding each grant until memory acknowledges.
module ptw_arbiter #(
  parameter bit FIXED_PRIO_D = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ptw_req,
  input  logic [31:0] i_ptw_addr,
  output logic [31:0] i_ptw_data,
  output logic        i_ptw_ack,
  input  logic        d_ptw_req,
  input  logic [31:0] d_ptw_addr,
  output logic [31:0] d_ptw_data,
  output logic        d_ptw_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_ack,
  output logic        busy,
  output logic        owner
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        abandoned_q, abandoned_d;
  logic        last_grant_q, last_grant_d;

  logic        win_d_s;
  logic        owner_req_s;
  logic        deliver_s;

  // Arbitration winner and the live request of the current owner.
  always_comb begin
    win_d_s     = d_ptw_req & (~i_ptw_req | (FIXED_PRIO_D == 1'b1) | (last_grant_q == SIDE_I));
    owner_req_s = (owner_q == SIDE_D) ? d_ptw_req : i_ptw_req;
  end

  // Next-state logic; an owner dropping its req marks the access abandoned
  // so the eventual memory ack is swallowed instead of forwarded.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    abandoned_d  = abandoned_q;
    last_grant_d = last_grant_q;
    deliver_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ptw_req | d_ptw_req) begin
          state_d      = ST_BUSY;
          owner_d      = win_d_s;
          addr_d       = win_d_s ? d_ptw_addr : i_ptw_addr;
          abandoned_d  = 1'b0;
          last_grant_d = win_d_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          deliver_s = ~abandoned_q & owner_req_s & ~rst;
        end else if (!owner_req_s) begin
          abandoned_d = 1'b1;
        end else begin
          abandoned_d = abandoned_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; last_grant resets to D so the
  // first contested round-robin grant goes to I.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= SIDE_I;
      addr_q       <= 32'h0000_0000;
      abandoned_q  <= 1'b0;
      last_grant_q <= SIDE_D;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      abandoned_q  <= abandoned_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Memory side comes only from registers; requester side is same-cycle from mem_ack.
  always_comb begin
    busy       = (state_q == ST_BUSY);
    mem_req    = busy;
    mem_addr   = busy ? addr_q : 32'h0000_0000;
    owner      = owner_q;
    i_ptw_ack  = deliver_s & (owner_q == SIDE_I);
    d_ptw_ack  = deliver_s & (owner_q == SIDE_D);
    i_ptw_data = i_ptw_ack ? mem_data : 32'h0000_0000;
    d_ptw_data = d_ptw_ack ? mem_data : 32'h0000_0000;
  end

endmodule
